// File: rtl/approx_adder_error_monitor_pkg.sv
// Shared definitions for the approximate-adder error monitor: sweep FSM
// encoding and the metric widths derived from the operand width.
package approx_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    function automatic int pair_w(input int w);
        return 2 * w;
    endfunction

    function automatic int err_cnt_w(input int w);
        return 2 * w + 1;
    endfunction

    function automatic int max_ed_w(input int w);
        return w + 1;
    endfunction

    function automatic int sum_ed_w(input int w);
        return 3 * w + 1;
    endfunction

endpackage

// File: rtl/approx_adder_error_monitor_if.sv
// Operand/result bus between the monitor (master) and the adder under test (slave).
interface approx_adder_error_monitor_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic             cin_out;
    logic [WIDTH:0]   approx_sum;

    modport master (output a_out, output b_out, output cin_out, input approx_sum);
    modport slave  (input a_out, input b_out, input cin_out, output approx_sum);
endinterface

// File: rtl/approx_adder_error_monitor_accum.sv
// Stage E registers the aligned exact/approx pair; stage A folds its error
// distance into the count, maximum and running-sum metrics.
module approx_err_accum
    import approx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr,
    input  logic                           valid,
    input  logic [WIDTH:0]                 exact,
    input  logic [WIDTH:0]                 approx,
    output logic [err_cnt_w(WIDTH)-1:0]    err_count,
    output logic [max_ed_w(WIDTH)-1:0]     max_ed,
    output logic [sum_ed_w(WIDTH)-1:0]     sum_ed
);
    localparam int EW = err_cnt_w(WIDTH);
    localparam int MW = max_ed_w(WIDTH);
    localparam int SW = sum_ed_w(WIDTH);

    logic             e_vld_q, e_vld_d;
    logic [WIDTH:0]   e_exact_q, e_exact_d;
    logic [WIDTH:0]   e_approx_q, e_approx_d;
    logic [EW-1:0]    err_q, err_d;
    logic [MW-1:0]    max_q, max_d;
    logic [SW-1:0]    sum_q, sum_d;
    logic [WIDTH+1:0] diff;
    logic [WIDTH:0]   ed;

    always_comb begin
        e_vld_d    = valid & ~clr;
        e_exact_d  = exact;
        e_approx_d = approx;

        // One extra bit keeps the sign, so the magnitude always fits WIDTH+1 bits.
        diff = {1'b0, e_exact_q} - {1'b0, e_approx_q};
        if (diff[WIDTH+1]) begin
            ed = ~diff[WIDTH:0] + (WIDTH+1)'(1);
        end else begin
            ed = diff[WIDTH:0];
        end

        err_d = err_q;
        max_d = max_q;
        sum_d = sum_q;
        if (clr) begin
            err_d = '0;
            max_d = '0;
            sum_d = '0;
        end else if (e_vld_q) begin
            err_d = err_q + EW'(ed != '0);
            sum_d = sum_q + SW'(ed);
            if (ed > max_q) begin
                max_d = ed;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_vld_q    <= 1'b0;
            e_exact_q  <= '0;
            e_approx_q <= '0;
            err_q      <= '0;
            max_q      <= '0;
            sum_q      <= '0;
        end else begin
            e_vld_q    <= e_vld_d;
            e_exact_q  <= e_exact_d;
            e_approx_q <= e_approx_d;
            err_q      <= err_d;
            max_q      <= max_d;
            sum_q      <= sum_d;
        end
    end

    assign err_count = err_q;
    assign max_ed    = max_q;
    assign sum_ed    = sum_q;

endmodule

// File: rtl/approx_adder_error_monitor.sv
// Exhaustive operand sweep around an approximate adder, with a latency-matched
// exact reference feeding the error-metric accumulator.
module approx_adder_error_monitor
    import approx_pkg::*;
#(
    parameter int   WIDTH   = DEF_WIDTH,
    parameter int   DUT_LAT = 0,
    parameter logic CIN_VAL = 1'b0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    approx_adder_error_monitor_if.master    adder,
    output logic                            busy,
    output logic                            done,
    output logic [err_cnt_w(WIDTH)-1:0]     err_count,
    output logic [max_ed_w(WIDTH)-1:0]      max_ed,
    output logic [sum_ed_w(WIDTH)-1:0]      sum_ed
);
    localparam int             PW         = pair_w(WIDTH);
    localparam logic [PW-1:0]  K_MAX      = '1;
    localparam logic [2:0]     DRAIN_LAST = 3'(DUT_LAT + 1);

    state_t         state_q, state_d;
    logic [PW-1:0]  k_q, k_d;
    logic [2:0]     drain_q, drain_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           clr;
    logic           valid_now;
    logic [WIDTH:0] exact_now;
    logic           vld_al;
    logic [WIDTH:0] exact_al;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        drain_d = drain_q;
        busy_d  = busy_q;
        done_d  = done_q;
        clr     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    k_d     = '0;
                    clr     = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            ST_RUN: begin
                if (k_q == K_MAX) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else begin
                    k_d = k_q + PW'(1);
                end
            end
            ST_DRAIN: begin
                // Wait for the last pair to clear the delay line, stage E and stage A.
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            drain_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            drain_q <= drain_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign adder.a_out   = k_q[PW-1:WIDTH];
    assign adder.b_out   = k_q[WIDTH-1:0];
    assign adder.cin_out = CIN_VAL;

    assign valid_now = (state_q == ST_RUN);
    assign exact_now = {1'b0, adder.a_out} + {1'b0, adder.b_out} + (WIDTH+1)'(CIN_VAL);

    if (DUT_LAT == 0) begin : g_no_delay
        assign vld_al   = valid_now;
        assign exact_al = exact_now;
    end else begin : g_delay
        logic [DUT_LAT-1:0] vld_q, vld_d;
        logic [WIDTH:0]     ex_q [DUT_LAT];
        logic [WIDTH:0]     ex_d [DUT_LAT];

        always_comb begin
            vld_d[0] = valid_now;
            ex_d[0]  = exact_now;
            for (int i = 1; i < DUT_LAT; i++) begin
                vld_d[i] = vld_q[i-1];
                ex_d[i]  = ex_q[i-1];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
                for (int i = 0; i < DUT_LAT; i++) begin
                    ex_q[i] <= '0;
                end
            end else begin
                vld_q <= vld_d;
                for (int i = 0; i < DUT_LAT; i++) begin
                    ex_q[i] <= ex_d[i];
                end
            end
        end

        assign vld_al   = vld_q[DUT_LAT-1];
        assign exact_al = ex_q[DUT_LAT-1];
    end

    approx_err_accum #(
        .WIDTH (WIDTH)
    ) u_accum (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .valid     (vld_al),
        .exact     (exact_al),
        .approx    (adder.approx_sum),
        .err_count (err_count),
        .max_ed    (max_ed),
        .sum_ed    (sum_ed)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// Bench for approx_adder_error_monitor: a 4-bit sweep against a two-stage
// registered adder model whose output can be exact, zeroed, LSB-flipped or misaligned.
module tb_approx_adder_error_monitor;

    localparam int W        = 4;
    localparam int LAT      = 2;
    localparam int NPAIRS   = 1 << (2 * W);
    localparam int BUSY_CYC = NPAIRS + LAT + 2;

    typedef struct {
        int    mode;
        int    exp_err;
        int    exp_max;
        int    exp_sum;
        string name;
    } vec_t;

    typedef struct {
        int err;
        int mx;
        int sm;
        int cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         busy;
    logic         done;
    logic [8:0]   err_count;
    logic [4:0]   max_ed;
    logic [12:0]  sum_ed;
    int           mode = 0;
    logic [W:0]   p1, p2;

    int           checks = 0;
    int           passes = 0;
    vec_t         vecs [4];
    exp_t         sbq [$];

    approx_adder_error_monitor_if #(.WIDTH(W)) bus ();

    approx_adder_error_monitor #(
        .WIDTH   (W),
        .DUT_LAT (LAT),
        .CIN_VAL (1'b0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .adder     (bus.master),
        .busy      (busy),
        .done      (done),
        .err_count (err_count),
        .max_ed    (max_ed),
        .sum_ed    (sum_ed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        p1 <= {1'b0, bus.a_out} + {1'b0, bus.b_out} + {{W{1'b0}}, bus.cin_out};
        p2 <= p1;
    end

    // Mode 3 taps the first stage only, i.e. the adder is one cycle faster than the monitor assumes.
    always_comb begin
        case (mode)
            1:       bus.approx_sum = '0;
            2:       bus.approx_sum = p2 ^ 5'd1;
            3:       bus.approx_sum = p1;
            default: bus.approx_sum = p2;
        endcase
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference for the misaligned case: pair k is compared with the exact sum of pair k+1,
    // and the final pair (held on the bus during drain) with itself.
    function automatic exp_t modelMisaligned();
        exp_t r;
        int   ex, ap, kn, ed;
        r = '{err: 0, mx: 0, sm: 0, cyc: BUSY_CYC};
        for (int k = 0; k < NPAIRS; k++) begin
            ex = (k >> W) + (k % (1 << W));
            kn = (k < NPAIRS - 1) ? k + 1 : k;
            ap = (kn >> W) + (kn % (1 << W));
            ed = (ex > ap) ? ex - ap : ap - ex;
            if (ed != 0) r.err++;
            if (ed > r.mx) r.mx = ed;
            r.sm += ed;
        end
        return r;
    endfunction

    task automatic applyStimulus(input int m, input vec_t v, input int pokeAt);
        exp_t e, got;
        int   c;
        int   it;
        e = '{err: v.exp_err, mx: v.exp_max, sm: v.exp_sum, cyc: BUSY_CYC};
        sbq.push_back(e);
        mode = m;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        checkOutput({v.name, "_start_a"}, bus.a_out, 0);
        checkOutput({v.name, "_start_b"}, bus.b_out, 0);
        checkOutput({v.name, "_start_busy"}, busy, 1);
        checkOutput({v.name, "_start_done"}, done, 0);
        checkOutput({v.name, "_start_err_clr"}, err_count, 0);
        checkOutput({v.name, "_start_sum_clr"}, sum_ed, 0);
        c  = 0;
        it = 0;
        while (done !== 1'b1 && it < 4 * BUSY_CYC) begin
            if (busy) c++;
            if (c == 18) begin
                checkOutput({v.name, "_pair17_a"}, bus.a_out, 1);
                checkOutput({v.name, "_pair17_b"}, bus.b_out, 1);
            end
            start = (pokeAt >= 0 && c == pokeAt + 1);
            it++;
            @(negedge clk);
        end
        start = 1'b0;
        got = sbq.pop_front();
        if (done !== 1'b1) begin
            checks++;
            $display("[TB] FAIL %s_done_timeout: done=%b after %0d cycles, required 1", v.name, done, it);
            return;
        end
        checkOutput({v.name, "_busy_cycles"}, c, got.cyc);
        checkOutput({v.name, "_busy_at_done"}, busy, 0);
        checkOutput({v.name, "_err_count"}, err_count, got.err);
        checkOutput({v.name, "_max_ed"}, max_ed, got.mx);
        checkOutput({v.name, "_sum_ed"}, sum_ed, got.sm);
        repeat (3) @(negedge clk);
        checkOutput({v.name, "_done_held"}, done, 1);
        checkOutput({v.name, "_err_frozen"}, err_count, got.err);
        checkOutput({v.name, "_last_a"}, bus.a_out, (1 << W) - 1);
        checkOutput({v.name, "_last_b"}, bus.b_out, (1 << W) - 1);
    endtask

    initial begin
        exp_t mis;
        vec_t rv;
        mis = modelMisaligned();
        vecs[0] = '{mode: 0, exp_err: 0,      exp_max: 0,      exp_sum: 0,      name: "exact"};
        vecs[1] = '{mode: 1, exp_err: 255,    exp_max: 30,     exp_sum: 3840,   name: "zero"};
        vecs[2] = '{mode: 2, exp_err: 256,    exp_max: 1,      exp_sum: 256,    name: "lsbflip"};
        vecs[3] = '{mode: 3, exp_err: mis.err, exp_max: mis.mx, exp_sum: mis.sm, name: "wronglat"};

        repeat (3) @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_a", bus.a_out, 0);
        checkOutput("reset_err", err_count, 0);
        checkOutput("reset_cin", bus.cin_out, 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_busy", busy, 0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].mode, vecs[i], -1);
        end

        rv = vecs[1];
        rv.name = "poke";
        applyStimulus(1, rv, 100);

        mode = 1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (100) @(negedge clk);
        checkOutput("pre_reset_err_nonzero", err_count != 0, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_a", bus.a_out, 0);
        checkOutput("abort_b", bus.b_out, 0);
        checkOutput("abort_err", err_count, 0);
        checkOutput("abort_max", max_ed, 0);
        checkOutput("abort_sum", sum_ed, 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort_idle_busy", busy, 0);

        rv = vecs[1];
        rv.name = "after_abort";
        applyStimulus(1, rv, -1);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/approx_adder_error_monitor.md
# approx_adder_error_monitor

Exhaustive stimulus generator and error-metric accumulator for the approximate 8-bit ripple-carry adders. It drives every (A, B) operand pair into an approximate adder under test and captures its 9-bit sum. It compares each captured sum against the exact sum and accumulates error count, maximum error distance and total error distance in hardware. The block sits around the adder under test and replaces offline post-processing of dumped result files for characterising each adder variant.

## Interface
Parameters:
- WIDTH, 8: operand width; the sweep covers 2^(2·WIDTH) pairs.
- DUT_LAT, 0: adder latency in cycles (0 = combinational), legal range 0..3.
- CIN_VAL, 0: constant carry-in driven to the adder.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begins a sweep; sampled only in IDLE or DONE.
- approx_sum  input  WIDTH+1  the adder's {Cout,S} result.
- a_out  output  WIDTH  operand A to the adder.
- b_out  output  WIDTH  operand B to the adder.
- cin_out  output  1  carry-in to the adder, constant CIN_VAL.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  high in DONE, held until the next accepted start.
- err_count  output  2·WIDTH+1  number of pairs with approx ≠ exact.
- max_ed  output  WIDTH+1  maximum |exact − approx|.
- sum_ed  output  3·WIDTH+1  sum of |exact − approx| over all pairs.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE or DONE with start=1: clear all metrics and the pair index, then go to RUN.
- RUN: pair index k counts 0..2^(2·WIDTH)−1.
  - a_out = k[2W−1:W] (outer loop) and b_out = k[W−1:0] (inner loop).
  - After k = max, go to DRAIN.
- DRAIN: stay DUT_LAT+2 cycles, then go to DONE.
- DONE: outputs are frozen. A new start restarts the sweep.
- start while busy is ignored.
- Exact sum = a_out + b_out + CIN_VAL, computed WIDTH+1 bits wide with no truncation.
- Error distance ed = |exact − approx_sum| as an unsigned WIDTH+1-bit value. The subtraction is done WIDTH+2 bits wide, then the magnitude is taken.
- On each valid pair:
  - err_count += (ed ≠ 0).
  - max_ed = max(max_ed, ed).
  - sum_ed += ed.
  - No saturation is needed; the widths are sized for the worst case.
- Reset: asynchronous clear to IDLE. All outputs are 0 at reset, including a_out, b_out, busy, done and the metrics; cin_out = CIN_VAL.
- Reset mid-sweep aborts the sweep with no partial result retained.

## Timing
- start sampled high at edge t: RUN begins at t+1 with a_out = b_out = 0 and busy = 1.
- Pair k is on a_out/b_out during RUN cycle k. Its approx_sum is sampled DUT_LAT cycles later.
- A delay line of depth DUT_LAT carries the valid bit and exact sum to align with approx_sum.
- Stage E registers exact, approx and the valid bit (+1 cycle). Stage A updates the accumulators (+1 cycle).
- Total busy cycles = 2^(2·WIDTH) + DUT_LAT + 2, i.e. 65538 for the defaults.
- done rises the cycle busy falls. The metrics are final and stable when done = 1.
- a_out/b_out hold their last pair through DRAIN and DONE.

## Structure
- Shared package/include approx_pkg holds:
  - the WIDTH-derived width constants (pair count, err_count/sum_ed widths);
  - the state encoding for IDLE/RUN/DRAIN/DONE.
- One sub-module, approx_err_accum: stage E plus stage A, with inputs valid/exact/approx and outputs for the three metrics.
- The top level holds the FSM, pair counter and latency delay line.

## Test plan
- Exact adder model connected, DUT_LAT=0:
  - err_count = 0, max_ed = 0, sum_ed = 0.
  - busy high for exactly 65538 cycles.
- approx_sum tied to 0:
  - err_count = 65535, max_ed = 510, sum_ed = 16711680.
- approx_sum = exact XOR 1 (LSB flip):
  - err_count = 65536, max_ed = 1, sum_ed = 65536.
- DUT_LAT=2 with a 2-stage registered exact adder:
  - all metrics 0, which proves the alignment.
  - Also with DUT_LAT=1 set wrongly: err_count ≠ 0.
- start pulsed again at RUN cycle 100: ignored, and the final metrics equal the unperturbed run.
  - Then start in DONE: done drops, metrics clear, the sweep restarts from pair 0.
- rst_n asserted at RUN cycle 30000:
  - all outputs 0 immediately, state IDLE.
  - A subsequent start yields the full correct results.
